// File: rtl/sqrt_rem_unit.sv
// sqrt_rem_unit: multi-cycle non-restoring integer square root with floor remainder and optional rounding
module sqrt_rem_unit #(
    parameter int SIZE = 64,
    parameter int BPC  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIZE-1:0]   num,
    input  logic              round_en,
    output logic              ready,
    output logic              busy,
    output logic [SIZE-1:0]   out,
    output logic [SIZE/2:0]   rem
);
    localparam int H  = SIZE / 2;
    localparam int RW = H + 3;
    localparam int N  = SIZE / (2 * BPC);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state_q, state_d;
    logic [SIZE-1:0] rad_q, rad_d, step_rad;
    logic [H-1:0]    root_q, root_d, step_root;
    logic [RW-1:0]   prem_q, prem_d, step_prem, shifted, fix_rem;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rnd_q, rnd_d, round_up;
    logic [SIZE-1:0] out_q, out_d;
    logic [H:0]      rem_q, rem_d;

    // resolve BPC root bits: sign of the partial remainder picks add or subtract of the trial term
    always_comb begin
        step_rad  = rad_q;
        step_root = root_q;
        step_prem = prem_q;
        shifted   = '0;
        for (int i = 0; i < BPC; i++) begin
            shifted   = {step_prem[RW-3:0], step_rad[SIZE-1 -: 2]};
            step_prem = step_prem[RW-1] ? shifted + {1'b0, step_root, 2'b11}
                                        : shifted - {1'b0, step_root, 2'b01};
            step_root = {step_root[H-2:0], ~step_prem[RW-1]};
            step_rad  = step_rad << 2;
        end
    end

    // a negative final remainder is restored by adding back 2r+1; rounding compares m against r
    assign fix_rem  = prem_q[RW-1] ? prem_q + {2'b00, root_q, 1'b1} : prem_q;
    assign round_up = rnd_q && (fix_rem > RW'(root_q));

    // next-state and datapath updates; start is honoured only in IDLE and DONE
    always_comb begin
        state_d = state_q;
        rad_d   = rad_q;
        root_d  = root_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        rnd_d   = rnd_q;
        out_d   = out_q;
        rem_d   = rem_q;
        case (state_q)
            CALC: begin
                rad_d  = step_rad;
                root_d = step_root;
                prem_d = step_prem;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) state_d = FIX;
            end
            FIX: begin
                out_d   = SIZE'(root_q) + SIZE'(round_up);
                rem_d   = fix_rem[H:0];
                state_d = DONE;
            end
            default: if (start) begin
                state_d = CALC;
                rad_d   = num;
                root_d  = '0;
                prem_d  = '0;
                cnt_d   = '0;
                rnd_d   = round_en;
            end
        endcase
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rad_q   <= '0;
            root_q  <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            rnd_q   <= 1'b0;
            out_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rad_q   <= rad_d;
            root_q  <= root_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            rnd_q   <= rnd_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
        end
    end

    assign ready = state_q == DONE;
    assign busy  = (state_q == CALC) || (state_q == FIX);
    assign out   = out_q;
    assign rem   = rem_q;
endmodule

// File: tb/tb_sqrt_rem_unit.sv
// tb_sqrt_rem_unit: scoreboard bench for sqrt_rem_unit with BPC=1 and BPC=2 instances
module tb_sqrt_rem_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_s[2];
    logic        rnd_s[2];
    logic        ready_s[2];
    logic        busy_s[2];
    logic [63:0] num_s[2];
    logic [63:0] out_s[2];
    logic [32:0] rem_s[2];
    logic        prev[2];

    typedef struct {
        logic [63:0] o;
        logic [32:0] r;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e;
    int   cmp = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    sqrt_rem_unit #(.SIZE(64), .BPC(1)) u1 (
        .clk(clk), .rst(rst), .start(start_s[0]), .num(num_s[0]), .round_en(rnd_s[0]),
        .ready(ready_s[0]), .busy(busy_s[0]), .out(out_s[0]), .rem(rem_s[0])
    );

    sqrt_rem_unit #(.SIZE(64), .BPC(2)) u2 (
        .clk(clk), .rst(rst), .start(start_s[1]), .num(num_s[1]), .round_en(rnd_s[1]),
        .ready(ready_s[1]), .busy(busy_s[1]), .out(out_s[1]), .rem(rem_s[1])
    );

    // reference: floor root by binary search over r*r <= n, then the rounding rule on m = n - r*r
    function automatic exp_t model(logic [63:0] n, logic rnd);
        logic [63:0] lo = 0;
        logic [63:0] hi = 64'hFFFF_FFFF;
        logic [63:0] mid;
        logic [63:0] m;
        exp_t x;
        while (lo < hi) begin
            mid = lo + (hi - lo + 1) / 2;
            if (mid * mid <= n) lo = mid;
            else hi = mid - 1;
        end
        m   = n - lo * lo;
        x.o = (rnd && m > lo) ? lo + 1 : lo;
        x.r = m[32:0];
        return x;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: each rising ready pops one expected result; ready/busy exclusivity every cycle
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ready_busy_excl_dut%0d", i), 64'(ready_s[i] & busy_s[i]), 64'd0);
            if (ready_s[i] === 1'b1 && prev[i] !== 1'b1) begin
                if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                    cmp++;
                    bad++;
                    $display("FAIL unexpected_result dut%0d: got out=%0d with no expected entry", i, out_s[i]);
                end else begin
                    if (i == 0) e = q0.pop_front();
                    else e = q1.pop_front();
                    chk($sformatf("out_dut%0d", i), out_s[i], e.o);
                    chk($sformatf("rem_dut%0d", i), 64'(rem_s[i]), 64'(e.r));
                end
            end
            prev[i] = ready_s[i];
        end
    end

    task automatic issue(int d, logic [63:0] n, logic r);
        @(negedge clk);
        start_s[d] = 1'b1;
        num_s[d]   = n;
        rnd_s[d]   = r;
        if (d == 0) q0.push_back(model(n, r));
        else q1.push_back(model(n, r));
        @(posedge clk);
        #1 start_s[d] = 1'b0;
    endtask

    task automatic wait_ready(int d, int exp_lat, string name);
        int lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!ready_s[d] && lat < 200);
        chk(name, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            rnd_s[i]   = 1'b0;
            num_s[i]   = '0;
            prev[i]    = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_out", out_s[i], 64'd0);
            chk("reset_rem", 64'(rem_s[i]), 64'd0);
            chk("reset_ready", 64'(ready_s[i]), 64'd0);
            chk("reset_busy", 64'(busy_s[i]), 64'd0);
        end
        @(negedge clk) rst = 1'b1;

        issue(0, 64'd0, 1'b0);
        wait_ready(0, 33, "latency_zero");
        issue(0, 64'd1000000, 1'b0);
        wait_ready(0, 33, "latency_1e6");
        issue(0, '1, 1'b0);
        wait_ready(0, 33, "latency_max_floor");
        issue(0, '1, 1'b1);
        wait_ready(0, 33, "latency_max_round");
        issue(0, 64'd8, 1'b1);
        wait_ready(0, 33, "latency_8r");
        issue(0, 64'd6, 1'b1);
        wait_ready(0, 33, "latency_6r");
        issue(0, 64'd6, 1'b0);
        wait_ready(0, 33, "latency_6f");

        repeat (5) @(posedge clk);
        #1;
        chk("done_hold_ready", 64'(ready_s[0]), 64'd1);
        chk("done_hold_out", out_s[0], 64'd2);
        chk("done_hold_rem", 64'(rem_s[0]), 64'd2);

        issue(0, 64'd1000000, 1'b0);
        chk("restart_ready_drop", 64'(ready_s[0]), 64'd0);
        chk("restart_out_held", out_s[0], 64'd2);
        wait_ready(0, 33, "latency_restart");

        issue(1, 64'd144, 1'b0);
        wait_ready(1, 17, "latency_bpc2_144");
        issue(1, 64'd8, 1'b1);
        wait_ready(1, 17, "latency_bpc2_8r");
        issue(1, 64'd144, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        start_s[1] = 1'b1;
        num_s[1]   = 64'd5;
        @(posedge clk);
        #1 start_s[1] = 1'b0;
        wait_ready(1, 13, "latency_bpc2_ignored_start");

        issue(0, {$urandom, $urandom}, 1'b0);
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        q0.delete();
        for (int i = 0; i < 2; i++) begin
            chk("async_reset_out", out_s[i], 64'd0);
            chk("async_reset_rem", 64'(rem_s[i]), 64'd0);
            chk("async_reset_ready", 64'(ready_s[i]), 64'd0);
            chk("async_reset_busy", 64'(busy_s[i]), 64'd0);
        end
        repeat (40) @(posedge clk);
        #1 chk("reset_no_ready", 64'(ready_s[0]), 64'd0);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("post_reset_idle_ready", 64'(ready_s[0]), 64'd0);
        issue(0, 64'd49, 1'b0);
        wait_ready(0, 33, "latency_49");

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            start_s[0] = 1'b1;
            num_s[0]   = {$urandom, $urandom};
            rnd_s[0]   = 1'($urandom_range(0, 1));
            q0.push_back(model(num_s[0], rnd_s[0]));
            @(posedge clk);
            repeat (33) @(posedge clk);
        end
        @(negedge clk) start_s[0] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained_dut0", 64'(q0.size()), 64'd0);
        chk("scoreboard_drained_dut1", 64'(q1.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule

// File: doc/sqrt_rem_unit.md
SQRT_REM_UNIT -- requirements
Module: sqrt_rem_unit

Interface
REQ-001 Parameter SIZE, default 64: radicand width in bits; even, >= 4.
REQ-002 Parameter BPC, default 1: root bits resolved per cycle; 1 or 2; (SIZE/2) divisible by BPC.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low (0 = reset asserted).
REQ-005 start  input  1  request a new operation; sampled on the rising clk edge.
REQ-006 num  input  SIZE  unsigned radicand; captured when start is accepted.
REQ-007 round_en  input  1  0 = floor root; 1 = round-to-nearest root; captured with num.
REQ-008 ready  output  1  high while a completed result is held on out/rem.
REQ-009 busy  output  1  high while an accepted operation is in progress.
REQ-010 out  output  SIZE  root, zero-extended to SIZE bits.
REQ-011 rem  output  SIZE/2+1  floor remainder: num - floor(sqrt(num))^2.

Function
REQ-012 States: IDLE, CALC, FIX, DONE; the reset state is IDLE.
REQ-013 start is accepted only in IDLE or DONE; start in CALC or FIX is ignored, with no effect on state or operands.
REQ-014 On acceptance: num and round_en are latched; the partial root, partial remainder and counter are cleared; state goes to CALC; busy=1 and ready=0 from the next cycle.
REQ-015 CALC: non-restoring digit-by-digit sqrt, BPC root bits per cycle, MSB first; it runs exactly N = SIZE/(2*BPC) cycles, then goes to FIX.
REQ-016 Internal remainder arithmetic uses a signed width of at least SIZE/2+2 bits; no intermediate overflow is permitted for any num.
REQ-017 FIX (1 cycle): a negative partial remainder is corrected; the floor root r and remainder m are formed; if round_en=1 and m > r, the root is r+1, otherwise r.
REQ-018 The tie case needs no rule because the true root is never exactly r+0.5 for integer num.
REQ-019 rem always reports the floor remainder m, independent of round_en.
REQ-020 On FIX exit: out and rem are updated, state goes to DONE, ready=1, busy=0.
REQ-021 Latency: start accepted at edge k -> ready high after edge k+N+1 (N+1 cycles).
REQ-022 DONE: out, rem and ready hold until the next accepted start.
REQ-023 start in DONE: ready drops the next cycle, CALC begins, and out/rem hold their old values until the new FIX.
REQ-024 start held high continuously: a new operation is accepted at every DONE, back-to-back, with no idle cycle.
REQ-025 ready and busy are never high in the same cycle.
REQ-026 Rounding never overflows out, because out is SIZE bits wide (e.g. the root may reach 2^(SIZE/2)).

Reset
REQ-027 While rst=0: out=0, rem=0, ready=0, busy=0, state=IDLE, and all internal registers are cleared, asynchronously and regardless of clk.
REQ-028 rst asserted mid-CALC/FIX aborts the operation; no result is produced and ready stays 0.
REQ-029 After rst deassertion the block waits in IDLE for start.

Verification (SIZE=64 unless noted)
REQ-030 BPC=1: num=0, round_en=0, start for 1 cycle -> ready after 33 cycles, out=0, rem=0; num=1000000 -> out=1000, rem=0.
REQ-031 num=2^64-1: round_en=0 -> out=4294967295, rem=8589934590; round_en=1 -> out=4294967296, rem=8589934590.
REQ-032 num=8, round_en=1 -> out=3, rem=4; num=6, round_en=1 -> out=2, rem=2; num=6, round_en=0 -> out=2.
REQ-033 BPC=2: num=144 -> ready after 17 cycles, out=12, rem=0; start pulsed in CALC with num=5 -> ignored, result still 12.
REQ-034 Reset: rst=0 at cycle 10 of CALC -> outputs 0 immediately, ready never rises; after rst=1, num=49 -> out=7, rem=0.
REQ-035 Throughput: start held high with 32 random {$random,$random} values -> each result equals a reference model (floor and rounded), with ready/busy mutually exclusive.
